// File: rtl/jleugeri_qubo_demon_core.sv
// Creutz-demon local search over N_VARS binary variables against an upper-triangular QUBO matrix.
// Each flip attempt takes N_VARS accumulate cycles plus one decide cycle; the best state seen is tracked.
module jleugeri_qubo_demon_core #(
  parameter int N_VARS    = 8,
  parameter int W_BITS    = 4,
  parameter int E_BITS    = 12,
  parameter int D_BITS    = 8,
  parameter int MAX_STEPS = 10_000_000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_we,
  input  logic [$clog2(N_VARS)-1:0] i_cfg_row,
  input  logic [$clog2(N_VARS)-1:0] i_cfg_col,
  input  logic signed [W_BITS-1:0]  i_cfg_wdata,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [D_BITS-1:0]         i_demon_init,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_VARS-1:0]         o_x_out,
  output logic signed [E_BITS-1:0]  o_energy_out,
  output logic [D_BITS-1:0]         o_demon_out,
  output logic [N_VARS-1:0]         o_best_x,
  output logic signed [E_BITS-1:0]  o_best_energy
);

  localparam int IW = $clog2(N_VARS);
  localparam int FW = W_BITS + IW + 1;
  localparam int CW = ((FW > D_BITS) ? FW : D_BITS) + 2;
  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [W_BITS-1:0]  r_q [N_VARS][N_VARS];
  logic [N_VARS-1:0]         r_x;
  logic [N_VARS-1:0]         r_best_x;
  logic signed [E_BITS-1:0]  r_e;
  logic signed [E_BITS-1:0]  r_best_e;
  logic [D_BITS-1:0]         r_demon;
  logic [SW-1:0]             r_step;
  logic [IW-1:0]             r_k;
  logic [IW-1:0]             r_j;
  logic signed [FW-1:0]      r_field;
  logic                      r_done;

  logic [IW-1:0]             w_lo;
  logic [IW-1:0]             w_hi;
  logic signed [W_BITS-1:0]  w_qkj;
  logic signed [FW-1:0]      w_term;
  logic signed [FW-1:0]      w_de;
  logic signed [CW-1:0]      w_de_c;
  logic signed [CW-1:0]      w_demon_c;
  logic signed [CW-1:0]      w_dnew;
  logic [D_BITS-1:0]         w_dsat;
  logic signed [E_BITS-1:0]  w_enew;
  logic [N_VARS-1:0]         w_xnew;
  logic                      w_accept;
  logic                      w_better;
  logic                      w_last;

  // Only the upper triangle is ever written, so reading at (min,max) covers both orderings.
  assign w_lo   = (r_k < r_j) ? r_k : r_j;
  assign w_hi   = (r_k < r_j) ? r_j : r_k;
  assign w_qkj  = r_q[w_lo][w_hi];
  assign w_term = ((r_j == r_k) || r_x[r_j]) ? FW'(w_qkj) : '0;

  assign w_de      = r_x[r_k] ? -r_field : r_field;
  assign w_de_c    = CW'(w_de);
  assign w_demon_c = CW'(r_demon);
  assign w_accept  = (w_de_c <= w_demon_c);
  // On accept the new demon is non-negative, so any upper bit set means it exceeds the D_BITS range.
  assign w_dnew    = w_demon_c - w_de_c;
  assign w_dsat    = (|w_dnew[CW-1:D_BITS]) ? '1 : w_dnew[D_BITS-1:0];
  assign w_enew    = r_e + E_BITS'(w_de);
  assign w_xnew    = r_x ^ (N_VARS'(1) << r_k);
  assign w_better  = (w_enew < r_best_e);
  assign w_last    = (r_step == SW'(MAX_STEPS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_ACCUM;
      S_ACCUM:  begin
        if (i_abort)                        w_next = S_IDLE;
        else if (r_j == IW'(N_VARS - 1))    w_next = S_DECIDE;
      end
      S_DECIDE: begin
        if (i_abort || w_last) w_next = S_IDLE;
        else                   w_next = S_ACCUM;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_VARS; i++)
        for (int j = 0; j < N_VARS; j++)
          r_q[i][j] <= '0;
      r_x      <= '0;
      r_best_x <= '0;
      r_e      <= '0;
      r_best_e <= '0;
      r_demon  <= '0;
      r_step   <= '0;
      r_k      <= '0;
      r_j      <= '0;
      r_field  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_cfg_we && (r_state == S_IDLE) && (i_cfg_row <= i_cfg_col))
        r_q[i_cfg_row][i_cfg_col] <= i_cfg_wdata;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x      <= '0;
            r_e      <= '0;
            r_demon  <= i_demon_init;
            r_best_x <= '0;
            r_best_e <= '0;
            r_step   <= '0;
            r_k      <= '0;
            r_j      <= '0;
            r_field  <= '0;
          end
        end
        S_ACCUM: begin
          if (!i_abort) begin
            r_field <= r_field + w_term;
            r_j     <= r_j + IW'(1);
          end
        end
        S_DECIDE: begin
          if (!i_abort) begin
            if (w_accept) begin
              r_x     <= w_xnew;
              r_e     <= w_enew;
              r_demon <= w_dsat;
              if (w_better) begin
                r_best_x <= w_xnew;
                r_best_e <= w_enew;
              end
            end
            r_k     <= r_k + IW'(1);
            r_step  <= r_step + SW'(1);
            r_field <= '0;
            r_done  <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_x_out       = r_x;
  assign o_energy_out  = r_e;
  assign o_demon_out   = r_demon;
  assign o_best_x      = r_best_x;
  assign o_best_energy = r_best_e;

endmodule
